alu_cmd_sequencer: RTL

Command front-end placed directly upstream of the 4-bit synchronous arithmetic unit. It accepts operation/operand commands over a valid/ready handshake, buffers them in a small FIFO, and drives the arithmetic unit's op/operand inputs one command at a time. It captures each registered result and returns it with its opcode over a second valid/ready handshake, so software-facing logic never needs to track the unit's one-cycle register latency.

---
 rtl/alu_cmd_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues one at a time and returns each result with its opcode; `define ALU_SEQ_DROP_CNT_EN adds o_drop_cnt
module alu_cmd_sequencer #(
  parameter int N = 2,
  parameter int M = 4,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [N-1:0]             i_cmd_op,
  input  logic [M-1:0]             i_cmd_a,
  input  logic [M-1:0]             i_cmd_b,
  output logic [N-1:0]             o_alu_op,
  output logic [M-1:0]             o_alu_arg_A,
  output logic [M-1:0]             o_alu_arg_B,
  input  logic [M-1:0]             i_alu_result,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [N-1:0]             o_rsp_op,
  output logic [M-1:0]             o_rsp_result,
  output logic [$clog2(DEPTH):0]   o_count
`ifdef ALU_SEQ_DROP_CNT_EN
  ,
  output logic [7:0]               o_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state_q, state_d;
  logic [N+2*M-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [N-1:0] rsp_op_q, rsp_op_d, alu_op_q, alu_op_d;
  logic [M-1:0] rsp_result_q, rsp_result_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic push, pop, rsp_hs;
  assign o_cmd_ready = count_q != CW'(DEPTH);
  assign o_count = count_q;
  assign o_alu_op = alu_op_q;
  assign o_alu_arg_A = alu_a_q;
  assign o_alu_arg_B = alu_b_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_op = rsp_op_q;
  assign o_rsp_result = rsp_result_q;
  always_comb begin
    push = i_cmd_valid && o_cmd_ready;
    rsp_hs = state_q == RESP && i_rsp_ready;
    pop = count_q != '0 && (state_q == IDLE || rsp_hs);
    state_d = pop ? ISSUE : state_q == ISSUE ? CAPTURE : state_q == CAPTURE ? RESP : rsp_hs ? IDLE : state_q;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    {alu_op_d, alu_a_d, alu_b_d} = pop ? mem_q[rd_q] : {alu_op_q, alu_a_q, alu_b_q};
    rsp_valid_d = state_q == CAPTURE || (rsp_valid_q && !rsp_hs);
    rsp_op_d = state_q == CAPTURE ? alu_op_q : rsp_op_q;
    rsp_result_d = state_q == CAPTURE ? i_alu_result : rsp_result_q;
  end
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q] <= {i_cmd_op, i_cmd_a, i_cmd_b};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q <= '0;
      rsp_result_q <= '0;
      alu_op_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q <= rsp_op_d;
      rsp_result_q <= rsp_result_d;
      alu_op_q <= alu_op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
    end
  end
`ifdef ALU_SEQ_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  assign o_drop_cnt = drop_q;
  always_comb begin
    drop_d = (i_cmd_valid && !o_cmd_ready && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
`endif
endmodule
